// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: walks a config table, issuing credited writes and serialized read-checks to the config endpoint.
module bp_cfg_loader #(
    parameter int cfg_addr_width_p  = 16,
    parameter int cfg_data_width_p  = 64,
    parameter int entry_count_p     = 64,
    parameter int max_outstanding_p = 4
) (
    input  logic                                     clk_i,
    input  logic                                     reset_ni,
    input  logic                                     start_i,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic                                     error_o,
    output logic                                     tbl_v_o,
    output logic [$clog2(entry_count_p)-1:0]         tbl_addr_o,
    input  logic [1+cfg_addr_width_p+cfg_data_width_p:0] tbl_data_i,
    output logic                                     cmd_v_o,
    output logic                                     cmd_w_o,
    output logic [cfg_addr_width_p-1:0]              cmd_addr_o,
    output logic [cfg_data_width_p-1:0]              cmd_data_o,
    input  logic                                     cmd_ready_i,
    input  logic                                     resp_v_i,
    input  logic [cfg_data_width_p-1:0]              resp_data_i,
    output logic                                     resp_yumi_o
);
    localparam int aw = cfg_addr_width_p;
    localparam int dw = cfg_data_width_p;
    localparam int ew = 2 + aw + dw;
    localparam int pw = $clog2(entry_count_p);
    localparam int cw = $clog2(max_outstanding_p + 1);

    typedef enum logic [3:0] {IDLE, FETCH, LATCH, ISSUE, RDWAIT, RDISSUE, RDRESP, DRAIN, DONE} state_e;

    state_e          state_q;
    logic [pw-1:0]   ptr_q;
    logic [cw-1:0]   credits_q, credits_d;
    logic [ew-1:0]   entry_q;
    logic [dw-1:0]   expect_q;
    logic            err_q;
    logic            cmd_hs, at_end, mismatch;

    assign at_end      = entry_q[ew-1] | (ptr_q == pw'(entry_count_p - 1));
    assign cmd_v_o     = (state_q == ISSUE && credits_q < cw'(max_outstanding_p)) || state_q == RDISSUE;
    assign cmd_w_o     = state_q == ISSUE;
    assign cmd_addr_o  = (state_q == ISSUE || state_q == RDISSUE) ? entry_q[dw +: aw] : '0;
    assign cmd_data_o  = state_q == ISSUE ? entry_q[dw-1:0] : '0;
    assign cmd_hs      = cmd_v_o & cmd_ready_i;
    // Stale responses (e.g. to commands abandoned by reset) are refused while nothing is owed.
    assign resp_yumi_o = resp_v_i & (credits_q != '0);
    assign credits_d   = credits_q + cw'(cmd_hs) - cw'(resp_yumi_o);
    assign mismatch    = resp_data_i != expect_q;
    assign busy_o      = !(state_q inside {IDLE, DONE});
    assign done_o      = state_q == DONE;
    assign error_o     = err_q;
    assign tbl_v_o     = state_q == FETCH;
    assign tbl_addr_o  = ptr_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            credits_q <= '0;
            entry_q   <= '0;
            expect_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            case (state_q)
                IDLE, DONE: if (start_i) begin
                    ptr_q   <= '0;
                    err_q   <= 1'b0;
                    state_q <= FETCH;
                end
                FETCH: state_q <= LATCH;
                LATCH: begin
                    entry_q <= tbl_data_i;
                    state_q <= tbl_data_i[ew-2] ? RDWAIT : ISSUE;
                end
                ISSUE: if (cmd_hs) begin
                    if (at_end) state_q <= DRAIN;
                    else begin
                        ptr_q   <= ptr_q + pw'(1);
                        state_q <= FETCH;
                    end
                end
                RDWAIT: if (credits_q == '0) state_q <= RDISSUE;
                RDISSUE: if (cmd_hs) begin
                    expect_q <= entry_q[dw-1:0];
                    state_q  <= RDRESP;
                end
                RDRESP: if (resp_yumi_o) begin
                    err_q <= err_q | mismatch;
                    if (err_q | mismatch | at_end) state_q <= DRAIN;
                    else begin
                        ptr_q   <= ptr_q + pw'(1);
                        state_q <= FETCH;
                    end
                end
                DRAIN: if (credits_q == '0) state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bp_cfg_loader.sv
// tb_bp_cfg_loader: scoreboard bench; a table-walking reference model predicts the command stream and final status.
module tb_bp_cfg_loader;
    localparam int A = 16, D = 16, N = 16, M = 4, E = 2 + A + D, PW = $clog2(N);

    typedef struct packed {logic w; logic [A-1:0] a; logic [D-1:0] d;} cmd_t;
    typedef struct packed {logic [D-1:0] d; int unsigned due;} rsp_t;

    logic clk_i = 0, reset_ni = 0, start_i = 0;
    logic busy_o, done_o, error_o, tbl_v_o, cmd_v_o, cmd_w_o, resp_yumi_o;
    logic [PW-1:0] tbl_addr_o;
    logic [E-1:0] tbl_data_i = '0;
    logic [A-1:0] cmd_addr_o;
    logic [D-1:0] cmd_data_o, resp_data_i = '0;
    logic cmd_ready_i = 0, resp_v_i = 0;

    logic [E-1:0] tbl [N];
    cmd_t exp_q[$];
    rsp_t pend[$];
    logic [D-1:0] mdl_mem[logic [A-1:0]];
    logic [D-1:0] ep_mem[logic [A-1:0]];
    int hs_rel[$];
    int unsigned cyc = 0;
    int tests = 0, fails = 0, hs_cnt = 0, start_cyc = 0;
    int ready_mode = 0, lat = 2, rel_grant = 0, rel_used = 0;
    bit rel_all = 1, resp_rand = 0, resp_force = 0;

    bp_cfg_loader #(.cfg_addr_width_p(A), .cfg_data_width_p(D), .entry_count_p(N), .max_outstanding_p(M)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .tbl_v_o(tbl_v_o), .tbl_addr_o(tbl_addr_o), .tbl_data_i(tbl_data_i),
        .cmd_v_o(cmd_v_o), .cmd_w_o(cmd_w_o), .cmd_addr_o(cmd_addr_o), .cmd_data_o(cmd_data_o),
        .cmd_ready_i(cmd_ready_i), .resp_v_i(resp_v_i), .resp_data_i(resp_data_i), .resp_yumi_o(resp_yumi_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    // Synchronous-read table: data appears the cycle after the read enable.
    always @(posedge clk_i) if (tbl_v_o) tbl_data_i <= tbl[tbl_addr_o];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy_o, done_o, error_o, tbl_v_o, tbl_addr_o, cmd_v_o, cmd_w_o, cmd_addr_o, cmd_data_o, resp_yumi_o});
    endfunction

    function automatic logic [E-1:0] ent(input logic l, input logic o, input logic [A-1:0] a, input logic [D-1:0] d);
        return {l, o, a, d};
    endfunction

    // Reference: walk entries in order; writes update the endpoint image, a read-check compares against it.
    task automatic model(output bit err);
        logic [E-1:0] t;
        logic [D-1:0] cur;
        err = 0;
        for (int i = 0; i < N; i++) begin
            t = tbl[i];
            if (t[E-2]) begin
                exp_q.push_back(cmd_t'({1'b0, t[D +: A], D'(0)}));
                cur = mdl_mem.exists(t[D +: A]) ? mdl_mem[t[D +: A]] : '0;
                if (cur != t[D-1:0]) begin
                    err = 1;
                    break;
                end
            end else begin
                exp_q.push_back(cmd_t'({1'b1, t[D +: A], t[D-1:0]}));
                mdl_mem[t[D +: A]] = t[D-1:0];
            end
            if (t[E-1]) break;
        end
    endtask

    task automatic fill_junk();
        for (int i = 0; i < N; i++) tbl[i] = E'({$urandom, $urandom});
    endtask

    task automatic gen_random(input int rd_pct);
        logic [D-1:0] scr[logic [A-1:0]];
        logic [A-1:0] a;
        logic [D-1:0] d;
        logic op;
        scr = mdl_mem;
        for (int i = 0; i < N; i++) begin
            a = A'(16'h0300 + 4 * $urandom_range(0, 3));
            op = $urandom_range(0, 99) < rd_pct;
            d = D'($urandom);
            if (op && $urandom_range(0, 3) != 0) d = scr.exists(a) ? scr[a] : '0;
            if (!op) scr[a] = d;
            tbl[i] = ent($urandom_range(0, 7) == 0, op, a, d);
        end
    endtask

    task automatic start_test(output bit exp_err);
        model(exp_err);
        @(posedge clk_i); #1 start_i = 1;
        @(posedge clk_i); #1 start_i = 0;
        start_cyc = int'(cyc) - 1;
        chk("after_start", {busy_o, done_o, error_o, tbl_v_o, tbl_addr_o}, {1'b1, 1'b0, 1'b0, 1'b1, PW'(0)});
    endtask

    task automatic finish_test(input bit exp_err);
        int n = 0;
        while (!done_o && n < 3000) begin
            @(posedge clk_i); #3;
            n++;
        end
        chk("done", done_o, 1);
        chk("error", error_o, exp_err);
        chk("busy_in_done", busy_o, 0);
        chk("cmds_left", exp_q.size(), 0);
    endtask

    task automatic monitor_loop();
        cmd_t e;
        forever begin
            @(negedge clk_i);
            if (reset_ni && cmd_v_o && cmd_ready_i) begin
                hs_cnt++;
                hs_rel.push_back(int'(cyc) - start_cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_cmd: got %0h expected none", {cmd_w_o, cmd_addr_o, cmd_data_o});
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd", 64'({cmd_w_o, cmd_addr_o, cmd_data_o}), 64'(e));
                end
            end
        end
    endtask

    // Endpoint: writes land in its register image at handshake; responses return after lat cycles.
    task automatic endpoint_loop();
        rsp_t r;
        bit ok;
        forever begin
            @(negedge clk_i);
            if (!reset_ni) begin
                pend.delete();
                ep_mem.delete();
            end else begin
                if (resp_yumi_o && pend.size() > 0) begin
                    r = pend.pop_front();
                    rel_used++;
                end
                if (cmd_v_o && cmd_ready_i) begin
                    r.d = cmd_w_o ? '0 : (ep_mem.exists(cmd_addr_o) ? ep_mem[cmd_addr_o] : '0);
                    if (cmd_w_o) ep_mem[cmd_addr_o] = cmd_data_o;
                    r.due = cyc + lat;
                    pend.push_back(r);
                end
            end
            @(posedge clk_i); #1;
            cmd_ready_i = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
            ok = pend.size() > 0 && pend[0].due <= cyc && (rel_all || rel_used < rel_grant) && (!resp_rand || $urandom_range(0, 2) != 0);
            resp_v_i = resp_force | ok;
            resp_data_i = ok ? pend[0].d : D'($urandom);
        end
    endtask

    initial begin
        bit e;
        int h0, n;
        fork
            monitor_loop();
            endpoint_loop();
        join_none
        repeat (3) @(posedge clk_i);
        #3 chk("reset_outputs", outs(), 0);
        @(posedge clk_i); #3 reset_ni = 1;

        // three writes, last on entry 2: commands on cycles 3, 6, 9
        fill_junk();
        tbl[0] = ent(0, 0, 16'h0100, 16'h1111);
        tbl[1] = ent(0, 0, 16'h0104, 16'h2222);
        tbl[2] = ent(1, 0, 16'h0108, 16'h3333);
        hs_rel.delete();
        start_test(e);
        finish_test(e);
        chk("cmd_count", hs_rel.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("cmd_cycle%0d", i), hs_rel[i], 3 * i + 3);

        // credit limit: eight writes with responses withheld
        fill_junk();
        for (int i = 0; i < 8; i++) tbl[i] = ent(i == 7, 0, A'(16'h0500 + i), D'($urandom));
        rel_all = 0;
        rel_grant = rel_used;
        h0 = hs_cnt;
        start_test(e);
        repeat (40) @(posedge clk_i);
        #3 chk("credit_cap_hs", hs_cnt - h0, 4);
        chk("credit_cap_cmd_v", cmd_v_o, 0);
        rel_grant = rel_used + 1;
        repeat (20) @(posedge clk_i);
        #3 chk("one_release_hs", hs_cnt - h0, 5);
        chk("one_release_cmd_v", cmd_v_o, 0);
        rel_all = 1;
        finish_test(e);

        // read-check match, then mismatch with trailing entries that must not issue
        fill_junk();
        tbl[0] = ent(0, 0, 16'h0200, 16'h0005);
        tbl[1] = ent(1, 1, 16'h0200, 16'h0005);
        start_test(e);
        finish_test(e);
        fill_junk();
        tbl[0] = ent(0, 0, 16'h0200, 16'h0007);
        tbl[1] = ent(0, 1, 16'h0200, 16'h0005);
        tbl[2] = ent(0, 0, 16'h0204, 16'h0009);
        tbl[3] = ent(1, 0, 16'h0208, 16'h000a);
        h0 = hs_cnt;
        start_test(e);
        finish_test(e);
        chk("mismatch_expected", e, 1);
        chk("mismatch_cmds", hs_cnt - h0, 2);

        // stall: command held stable while cmd_ready_i is low
        fill_junk();
        tbl[0] = ent(0, 0, 16'h0400, 16'hbeef);
        tbl[1] = ent(1, 0, 16'h0404, 16'hcafe);
        ready_mode = 2;
        h0 = hs_cnt;
        start_test(e);
        n = 0;
        while (!cmd_v_o && n < 20) begin
            @(posedge clk_i); #3;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {cmd_v_o, cmd_w_o, cmd_addr_o, cmd_data_o}, {1'b1, 1'b1, 16'h0400, 16'hbeef});
            @(posedge clk_i); #3;
        end
        chk("stall_no_hs", hs_cnt - h0, 0);
        ready_mode = 0;
        finish_test(e);
        chk("stall_total_hs", hs_cnt - h0, 2);

        // no last bit: stops at the final entry; a start while busy is ignored
        for (int i = 0; i < N; i++) tbl[i] = ent(0, 0, A'(16'h0600 + i), D'($urandom));
        ready_mode = 1;
        lat = 3;
        h0 = hs_cnt;
        start_test(e);
        repeat (10) @(posedge clk_i);
        #1 start_i = 1;
        @(posedge clk_i); #1 start_i = 0;
        finish_test(e);
        chk("table_end_hs", hs_cnt - h0, N);

        // asynchronous reset mid-ISSUE with two outstanding
        fill_junk();
        for (int i = 0; i < 8; i++) tbl[i] = ent(i == 7, 0, A'(16'h0700 + i), D'($urandom));
        ready_mode = 0;
        rel_all = 0;
        rel_grant = rel_used;
        h0 = hs_cnt;
        start_test(e);
        n = 0;
        while (hs_cnt - h0 < 2 && n < 50) begin
            @(posedge clk_i); #3;
            n++;
        end
        ready_mode = 2;
        n = 0;
        while (!cmd_v_o && n < 20) begin
            @(posedge clk_i); #3;
            n++;
        end
        chk("pre_reset_hs", hs_cnt - h0, 2);
        resp_force = 1;
        @(posedge clk_i); #3;
        chk("pre_reset_yumi", resp_yumi_o, 1);
        reset_ni = 0;
        #1 chk("async_reset_outputs", outs(), 0);
        exp_q.delete();
        mdl_mem.delete();
        resp_force = 0;
        rel_all = 1;
        ready_mode = 0;
        repeat (3) @(posedge clk_i);
        #3 reset_ni = 1;
        for (int i = 0; i < N; i++) tbl[i] = ent(i == 5, 0, A'(16'h0800 + i), D'($urandom));
        start_test(e);
        finish_test(e);

        // randomized tables and endpoint behaviour
        for (int t = 0; t < 25; t++) begin
            gen_random(35);
            ready_mode = $urandom_range(0, 1);
            lat = $urandom_range(1, 6);
            resp_rand = $urandom_range(0, 1) == 1;
            start_test(e);
            finish_test(e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
